// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage feeding the instruction decoder. Generates the PC, issues reads
// to a one-cycle-latency synchronous instruction memory, buffers returned
// words in a small prefetch FIFO and hands them to the decoder with a
// valid/ready handshake. A redirect from execute flushes everything buffered
// or in flight and restarts fetch at the new address.
//
// Optional feature macro: IFU_STATIC_PREDICT_EN
//   When defined, backward branches seen on the response path are predicted
//   taken and fetch jumps to the branch target immediately.

module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    // Pointer width indexes DEPTH entries; count needs one more bit to hold DEPTH.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    req_pc_q, req_pc_d;
    logic           inflight_q, inflight_d;
    logic           killed_q, killed_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;

    logic [31:0]    mem_pc_q   [DEPTH];
    logic [31:0]    mem_data_q [DEPTH];

    logic [CW:0]    occupancy;
    logic           issue;
    logic           push;
    logic           pop;
    logic           predict_hit;

`ifdef IFU_STATIC_PREDICT_EN
    logic [31:0]    predict_target;
`endif

    // Entries already buffered plus the one that may still be returning;
    // issuing only below DEPTH guarantees every response finds a free slot.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows fetch_en; request strobe only while running and not redirecting.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!fetch_en) begin
                    state_d = IDLE;
                end
                imem_req = (occupancy < DEPTH_OCC) && !redirect_valid;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake qualifiers; a redirect suppresses both push and pop because it flushes anyway.
    always_comb begin
        issue       = imem_req;
        push        = inflight_q && !killed_q && !redirect_valid;
        instr_valid = (count_q != '0);
        pop         = instr_valid && instr_ready && !redirect_valid;
    end

`ifdef IFU_STATIC_PREDICT_EN
    // Backward branch (opcode bits 27:26 = 10 with negative offset) is predicted taken.
    always_comb begin
        predict_hit    = push && (imem_rdata[27:26] == 2'b10) && imem_rdata[23];
        predict_target = req_pc_q + 32'd8 + {{6{imem_rdata[23]}}, imem_rdata[23:0], 2'b00};
    end
`else
    // Without prediction fetch is purely sequential between redirects.
    always_comb begin
        predict_hit = 1'b0;
    end
`endif

    // PC and in-flight bookkeeping: redirect beats prediction beats sequential advance.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        killed_d   = issue && predict_hit;
        if (issue) begin
            req_pc_d = pc_q;
        end
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
`ifdef IFU_STATIC_PREDICT_EN
        end else if (predict_hit) begin
            pc_d = predict_target;
`endif
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // FIFO occupancy and pointers; simultaneous push and pop leave count unchanged.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC & ~32'h3;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            killed_q   <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            killed_q   <= killed_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero until first fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else if (push) begin
            mem_pc_q[wr_ptr_q]   <= req_pc_q;
            mem_data_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Head outputs come straight from registered storage, independent of instr_ready.
    always_comb begin
        imem_addr = pc_q;
        instr     = mem_data_q[rd_ptr_q];
        instr_pc  = mem_pc_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit: reset values, sequential streaming,
// back-pressure, redirect flush, redirect with disable, PC wrap, static
// prediction (IFU_STATIC_PREDICT_EN aware) and reset mid-operation.

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetchEn;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrWord;
    logic [31:0] instrPc;

    logic        branchMode;
    int          testsRun;
    int          testsFailed;

    instr_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetchEn),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_rdata     (imemRdata),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .instr_valid    (instrValid),
        .instr_ready    (instrReady),
        .instr          (instrWord),
        .instr_pc       (instrPc)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: address-derived words, with a backward branch at 0x40 in branch mode.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (branchMode && addr == 32'h0000_0040) begin
            return 32'hEAFF_FFFE;
        end
        return addr ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory: data appears the cycle after the request.
    always @(posedge clk) begin
        if (imemReq) begin
            imemRdata <= memWord(imemAddr);
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n         = 1'b0;
        fetchEn       = 1'b0;
        instrReady    = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        fetchEn       = 1'b0;
        instrReady    = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        tick();
        testsRun++;
        if (imemReq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_req: got %b, expected 0", imemReq);
        end
        testsRun++;
        if (imemAddr !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_addr: got %h, expected 00000000", imemAddr);
        end
        testsRun++;
        if (instrValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", instrValid);
        end
        testsRun++;
        if (instrWord !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_instr: got %h, expected 00000000", instrWord);
        end
        testsRun++;
        if (instrPc !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_instr_pc: got %h, expected 00000000", instrPc);
        end
        rst_n = 1'b1;
        tick();
        testsRun++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_quiet: got req=%b valid=%b, expected 0 0", imemReq, instrValid);
        end
    endtask

    task automatic test_sequential();
        int firstReq;
        int firstValid;
        logic [31:0] expPc;
        doReset();
        fetchEn    = 1'b1;
        instrReady = 1'b1;
        firstReq   = -1;
        firstValid = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (imemReq && firstReq < 0) firstReq = c;
            if (instrValid) begin
                firstValid = c;
                break;
            end
        end
        testsRun++;
        if (firstReq < 0 || firstValid < 0 || (firstValid - firstReq) != 2) begin
            testsFailed++;
            $display("[TB] FAIL seq_latency: got req@%0d valid@%0d, expected valid 2 cycles after req", firstReq, firstValid);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            expPc = 32'(k * 4);
            testsRun++;
            if (instrValid !== 1'b1 || instrPc !== expPc) begin
                testsFailed++;
                $display("[TB] FAIL seq_pc[%0d]: got valid=%b pc=%h, expected 1 %h", k, instrValid, instrPc, expPc);
            end
            testsRun++;
            if (instrWord !== (expPc ^ 32'hA5A5_0000)) begin
                testsFailed++;
                $display("[TB] FAIL seq_instr[%0d]: got %h, expected %h", k, instrWord, expPc ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expPc;
        doReset();
        fetchEn    = 1'b1;
        instrReady = 1'b0;
        repeat (10) tick();
        testsRun++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL bp_head: got valid=%b pc=%h, expected 1 00000000", instrValid, instrPc);
        end
        testsRun++;
        if (imemReq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_req_stopped: got %b, expected 0", imemReq);
        end
        tick();
        testsRun++;
        if (instrPc !== 32'h0 || instrWord !== 32'hA5A5_0000) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold: got pc=%h instr=%h, expected 00000000 a5a50000", instrPc, instrWord);
        end
        instrReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            expPc = 32'(k * 4);
            testsRun++;
            if (instrValid !== 1'b1 || instrPc !== expPc) begin
                testsFailed++;
                $display("[TB] FAIL bp_drain[%0d]: got valid=%b pc=%h, expected 1 %h", k, instrValid, instrPc, expPc);
            end
        end
    endtask

    task automatic test_redirect();
        bit found;
        doReset();
        fetchEn    = 1'b1;
        instrReady = 1'b0;
        found      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (instrValid && !imemReq) begin
                found = 1'b1;
                break;
            end
        end
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL redir_fill: got no full state, expected valid with req low within 20 cycles");
        end
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0103;
        #1;
        testsRun++;
        if (imemReq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL redir_no_issue: got %b, expected 0", imemReq);
        end
        tick();
        redirectValid = 1'b0;
        #1;
        testsRun++;
        if (instrValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL redir_flush: got valid=%b, expected 0", instrValid);
        end
        testsRun++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0000_0100) begin
            testsFailed++;
            $display("[TB] FAIL redir_new_req: got req=%b addr=%h, expected 1 00000100", imemReq, imemAddr);
        end
        tick();
        testsRun++;
        if (instrValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL redir_stale_drop: got valid=%b pc=%h, expected 0", instrValid, instrPc);
        end
        tick();
        testsRun++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0000_0100 || instrWord !== 32'hA5A5_0100) begin
            testsFailed++;
            $display("[TB] FAIL redir_first: got valid=%b pc=%h instr=%h, expected 1 00000100 a5a50100", instrValid, instrPc, instrWord);
        end
        instrReady = 1'b1;
        tick();
        testsRun++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0000_0104) begin
            testsFailed++;
            $display("[TB] FAIL redir_second: got valid=%b pc=%h, expected 1 00000104", instrValid, instrPc);
        end
    endtask

    task automatic test_redirect_pop_disable();
        bit found;
        doReset();
        fetchEn    = 1'b1;
        instrReady = 1'b1;
        found      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (instrValid) begin
                found = 1'b1;
                break;
            end
        end
        tick();
        testsRun++;
        if (!found || instrPc !== 32'h0000_0004) begin
            testsFailed++;
            $display("[TB] FAIL rpd_stream: got found=%b pc=%h, expected 1 00000004", found, instrPc);
        end
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0200;
        tick();
        redirectValid = 1'b0;
        #1;
        testsRun++;
        if (instrValid !== 1'b0 || imemAddr !== 32'h0000_0200) begin
            testsFailed++;
            $display("[TB] FAIL rpd_flush: got valid=%b addr=%h, expected 0 00000200", instrValid, imemAddr);
        end
        tick();
        testsRun++;
        if (instrValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rpd_no_stale: got valid=%b pc=%h, expected 0", instrValid, instrPc);
        end
        tick();
        testsRun++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0000_0200) begin
            testsFailed++;
            $display("[TB] FAIL rpd_target: got valid=%b pc=%h, expected 1 00000200", instrValid, instrPc);
        end
        fetchEn = 1'b0;
        tick();
        testsRun++;
        if (imemReq !== 1'b0 || instrValid !== 1'b1 || instrPc !== 32'h0000_0204) begin
            testsFailed++;
            $display("[TB] FAIL rpd_inflight1: got req=%b valid=%b pc=%h, expected 0 1 00000204", imemReq, instrValid, instrPc);
        end
        tick();
        testsRun++;
        if (imemReq !== 1'b0 || instrValid !== 1'b1 || instrPc !== 32'h0000_0208) begin
            testsFailed++;
            $display("[TB] FAIL rpd_inflight2: got req=%b valid=%b pc=%h, expected 0 1 00000208", imemReq, instrValid, instrPc);
        end
        tick();
        testsRun++;
        if (instrValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rpd_drained: got valid=%b pc=%h, expected 0", instrValid, instrPc);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            testsRun++;
            if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL rpd_quiet[%0d]: got req=%b valid=%b, expected 0 0", k, imemReq, instrValid);
            end
        end
    endtask

    task automatic test_pc_wrap();
        bit found;
        doReset();
        fetchEn       = 1'b1;
        instrReady    = 1'b1;
        redirectValid = 1'b1;
        redirectPc    = 32'hFFFF_FFF8;
        tick();
        redirectValid = 1'b0;
        found         = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (instrValid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        testsRun++;
        if (!found || instrPc !== 32'hFFFF_FFF8) begin
            testsFailed++;
            $display("[TB] FAIL wrap_0: got found=%b pc=%h, expected 1 fffffff8", found, instrPc);
        end
        tick();
        testsRun++;
        if (instrValid !== 1'b1 || instrPc !== 32'hFFFF_FFFC) begin
            testsFailed++;
            $display("[TB] FAIL wrap_1: got valid=%b pc=%h, expected 1 fffffffc", instrValid, instrPc);
        end
        tick();
        testsRun++;
        if (instrValid !== 1'b1 || instrPc !== 32'h0000_0000 || instrWord !== 32'hA5A5_0000) begin
            testsFailed++;
            $display("[TB] FAIL wrap_2: got valid=%b pc=%h instr=%h, expected 1 00000000 a5a50000", instrValid, instrPc, instrWord);
        end
    endtask

    task automatic test_predict();
        bit found;
        logic [31:0] expNext;
`ifdef IFU_STATIC_PREDICT_EN
        expNext = 32'h0000_0040;
`else
        expNext = 32'h0000_0044;
`endif
        branchMode = 1'b1;
        doReset();
        fetchEn       = 1'b1;
        instrReady    = 1'b1;
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0040;
        tick();
        redirectValid = 1'b0;
        found         = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (instrValid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        testsRun++;
        if (!found || instrPc !== 32'h0000_0040 || instrWord !== 32'hEAFF_FFFE) begin
            testsFailed++;
            $display("[TB] FAIL pred_branch: got found=%b pc=%h instr=%h, expected 1 00000040 eafffffe", found, instrPc, instrWord);
        end
        tick();
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (instrValid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        testsRun++;
        if (!found || instrPc !== expNext) begin
            testsFailed++;
            $display("[TB] FAIL pred_next: got found=%b pc=%h, expected 1 %h", found, instrPc, expNext);
        end
        branchMode = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        doReset();
        fetchEn    = 1'b1;
        instrReady = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (instrValid !== 1'b0 || imemReq !== 1'b0 || instrWord !== 32'h0 || instrPc !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_clear: got valid=%b req=%b instr=%h pc=%h, expected 0 0 0 0", instrValid, imemReq, instrWord, instrPc);
        end
        tick();
        fetchEn = 1'b0;
        rst_n   = 1'b1;
        tick();
        tick();
        testsRun++;
        if (instrValid !== 1'b0 || imemReq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_discard: got valid=%b req=%b, expected 0 0", instrValid, imemReq);
        end
        fetchEn    = 1'b1;
        instrReady = 1'b1;
        found      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (instrValid) begin
                found = 1'b1;
                break;
            end
        end
        testsRun++;
        if (!found || instrPc !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_restart: got found=%b pc=%h, expected 1 00000000", found, instrPc);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        branchMode    = 1'b0;
        rst_n         = 1'b0;
        fetchEn       = 1'b0;
        instrReady    = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_pop_disable();
        test_pc_wrap();
        test_predict();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
